// File: rtl/machine_timer_bus_adapter_pkg.sv
// Shared definitions for the machine timer bus adapter: register offsets,
// FSM state type, idle read select and the byte-merge helper.
package machine_timer_bus_adapter_pkg;

   localparam int unsigned MTIMER_XLEN = 32;
   localparam int unsigned MTIMER_BE_W = MTIMER_XLEN / 8;

   localparam logic [3:0] MTIMER_OFS_MTIME_LO = 4'h0;
   localparam logic [3:0] MTIMER_OFS_MTIME_HI = 4'h4;
   localparam logic [3:0] MTIMER_OFS_CMP_LO   = 4'h8;
   localparam logic [3:0] MTIMER_OFS_CMP_HI   = 4'hC;

   // Parking select: 2'b00 would make the timer re-snapshot mtime high.
   localparam logic [1:0] MTIMER_SEL_IDLE = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_CAP  = 2'd2
   } mtimer_state_e;

   // Enabled bytes come from new_word, the rest from old_word.
   function automatic logic [MTIMER_XLEN-1:0] mtimer_byte_merge(
      input logic [MTIMER_XLEN-1:0] old_word,
      input logic [MTIMER_XLEN-1:0] new_word,
      input logic [MTIMER_BE_W-1:0] byte_en
   );
      logic [MTIMER_XLEN-1:0] merged;
      merged = old_word;
      for (int unsigned i = 0; i < MTIMER_BE_W; i++) begin
         if (byte_en[i]) merged[8*i +: 8] = new_word[8*i +: 8];
      end
      return merged;
   endfunction

endpackage

// File: rtl/machine_timer_bus_adapter.sv
// Bus bridge from the data-memory port to the machine timer register file.
// Optional feature: MTIMER_BYTE_ENABLE_EN enables read-modify-write of partial mtimecmp writes.
module machine_timer_bus_adapter
   import machine_timer_bus_adapter_pkg::*;
#(
   parameter int unsigned            ADDR_WIDTH = 32,
   parameter int unsigned            XLEN       = 32,
   parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR  = 32'h2000_0000
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  sync_reset,
   input  logic                  mem_re,
   input  logic                  mem_we,
   input  logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [XLEN-1:0]       mem_write_data,
   input  logic [XLEN/8-1:0]     mem_byte_en,
   output logic                  mem_ready,
   output logic                  mem_ack,
   output logic [XLEN-1:0]       mem_read_data,
   output logic                  access_error,
   output logic                  load_mtimecmp_low,
   output logic                  load_mtimecmp_high,
   output logic [XLEN-1:0]       mtimecmp_write_data,
   output logic [1:0]            reg_read_addr,
   input  logic [XLEN-1:0]       reg_read_data
);

   mtimer_state_e      state_q;
   logic               ack_q;
   logic               err_q;
   logic               ld_lo_q;
   logic               ld_hi_q;
   logic [XLEN-1:0]    rdata_q;
   logic [XLEN-1:0]    cmp_wdata_q;
   logic [1:0]         sel_q;
   logic               rmw_q;
   logic               rmw_hi_q;
   logic [XLEN-1:0]    rmw_data_q;
   logic [XLEN/8-1:0]  rmw_be_q;

   logic hit_c;
   logic aligned_c;
   logic is_cmp_c;
   logic is_cmp_hi_c;
   logic wr_c;
   logic rd_c;
   logic rmw_c;
   logic be_none_c;
   logic start_seq_c;

   // Address decode; write has priority over a simultaneous read.
   assign hit_c       = (mem_addr[ADDR_WIDTH-1:4] == BASE_ADDR[ADDR_WIDTH-1:4]);
   assign aligned_c   = (mem_addr[1:0] == 2'b00);
   assign is_cmp_hi_c = (mem_addr[3:2] == MTIMER_OFS_CMP_HI[3:2]);
   assign is_cmp_c    = (mem_addr[3:2] == MTIMER_OFS_CMP_LO[3:2]) || is_cmp_hi_c;
   assign wr_c        = mem_ready && hit_c && mem_we;
   assign rd_c        = mem_ready && hit_c && mem_re && !mem_we;

`ifdef MTIMER_BYTE_ENABLE_EN
   assign be_none_c = (mem_byte_en == '0);
   assign rmw_c     = !be_none_c && (mem_byte_en != '1);
`else
   logic unused_byte_en;
   assign unused_byte_en = ^mem_byte_en;
   assign be_none_c      = 1'b0;
   assign rmw_c          = 1'b0;
`endif

   assign start_seq_c = aligned_c && (rd_c || (wr_c && is_cmp_c && rmw_c));

   // Sequencing FSM: reads and RMW writes walk IDLE -> WAIT -> CAP -> IDLE.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
      end else if (sync_reset) begin
         state_q <= ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: if (start_seq_c) state_q <= ST_WAIT;
            ST_WAIT: state_q <= ST_CAP;
            ST_CAP:  state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Registered bus responses, timer strobes and read select.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ack_q       <= 1'b0;
         err_q       <= 1'b0;
         ld_lo_q     <= 1'b0;
         ld_hi_q     <= 1'b0;
         rdata_q     <= '0;
         cmp_wdata_q <= '0;
         sel_q       <= MTIMER_SEL_IDLE;
         rmw_q       <= 1'b0;
         rmw_hi_q    <= 1'b0;
         rmw_data_q  <= '0;
         rmw_be_q    <= '0;
      end else if (sync_reset) begin
         ack_q       <= 1'b0;
         err_q       <= 1'b0;
         ld_lo_q     <= 1'b0;
         ld_hi_q     <= 1'b0;
         rdata_q     <= '0;
         cmp_wdata_q <= '0;
         sel_q       <= MTIMER_SEL_IDLE;
         rmw_q       <= 1'b0;
         rmw_hi_q    <= 1'b0;
         rmw_data_q  <= '0;
         rmw_be_q    <= '0;
      end else begin
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         ld_lo_q <= 1'b0;
         ld_hi_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (wr_c) begin
                  if (!aligned_c) begin
                     ack_q   <= 1'b1;
                     err_q   <= 1'b1;
                     rdata_q <= '0;
                  end else if (!is_cmp_c) begin
                     ack_q <= 1'b1;
                     err_q <= 1'b1;
                  end else if (rmw_c) begin
                     rmw_q      <= 1'b1;
                     rmw_hi_q   <= is_cmp_hi_c;
                     rmw_data_q <= mem_write_data;
                     rmw_be_q   <= mem_byte_en;
                     sel_q      <= mem_addr[3:2];
                  end else if (be_none_c) begin
                     ack_q <= 1'b1;
                  end else begin
                     ld_lo_q     <= !is_cmp_hi_c;
                     ld_hi_q     <= is_cmp_hi_c;
                     cmp_wdata_q <= mem_write_data;
                     ack_q       <= 1'b1;
                  end
               end else if (rd_c) begin
                  if (!aligned_c) begin
                     ack_q   <= 1'b1;
                     err_q   <= 1'b1;
                     rdata_q <= '0;
                  end else begin
                     rmw_q <= 1'b0;
                     sel_q <= mem_addr[3:2];
                  end
               end
            end
            // Park the select as soon as the timer has sampled it so the
            // mtime-high snapshot stays tied to the low-word read.
            ST_WAIT: sel_q <= MTIMER_SEL_IDLE;
            ST_CAP: begin
               ack_q <= 1'b1;
               if (rmw_q) begin
                  ld_lo_q     <= !rmw_hi_q;
                  ld_hi_q     <= rmw_hi_q;
                  cmp_wdata_q <= mtimer_byte_merge(reg_read_data, rmw_data_q, rmw_be_q);
               end else begin
                  rdata_q <= reg_read_data;
               end
            end
            default: ;
         endcase
      end
   end

   assign mem_ready           = (state_q == ST_IDLE);
   assign mem_ack             = ack_q;
   assign access_error        = err_q;
   assign load_mtimecmp_low   = ld_lo_q;
   assign load_mtimecmp_high  = ld_hi_q;
   assign mem_read_data       = rdata_q;
   assign mtimecmp_write_data = cmp_wdata_q;
   assign reg_read_addr       = sel_q;

endmodule

// File: tb/tb_machine_timer_bus_adapter.sv
// Self-checking bench for machine_timer_bus_adapter with a behavioural timer
// and a transaction-level reference model.
module tb_machine_timer_bus_adapter;

   localparam logic [31:0] BASE = 32'h2000_0000;

   logic        clk;
   logic        reset_n;
   logic        sync_reset;
   logic        mem_re;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_write_data;
   logic [3:0]  mem_byte_en;
   logic        mem_ready;
   logic        mem_ack;
   logic [31:0] mem_read_data;
   logic        access_error;
   logic        load_mtimecmp_low;
   logic        load_mtimecmp_high;
   logic [31:0] mtimecmp_write_data;
   logic [1:0]  reg_read_addr;
   logic [31:0] reg_read_data;

   int n_cmp = 0;
   int n_bad = 0;

   machine_timer_bus_adapter dut (
      .clk                 (clk),
      .reset_n             (reset_n),
      .sync_reset          (sync_reset),
      .mem_re              (mem_re),
      .mem_we              (mem_we),
      .mem_addr            (mem_addr),
      .mem_write_data      (mem_write_data),
      .mem_byte_en         (mem_byte_en),
      .mem_ready           (mem_ready),
      .mem_ack             (mem_ack),
      .mem_read_data       (mem_read_data),
      .access_error        (access_error),
      .load_mtimecmp_low   (load_mtimecmp_low),
      .load_mtimecmp_high  (load_mtimecmp_high),
      .mtimecmp_write_data (mtimecmp_write_data),
      .reg_read_addr       (reg_read_addr),
      .reg_read_data       (reg_read_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural machine timer: registered read port, mtime-high snapshot on select 00.
   logic [63:0] mtime;
   logic [31:0] t_cmp_lo, t_cmp_hi, t_snap;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         reg_read_data <= 32'h0;
         t_snap        <= 32'h0;
         t_cmp_lo      <= 32'h0;
         t_cmp_hi      <= 32'h0;
      end else begin
         if (reg_read_addr == 2'b00) t_snap <= mtime[63:32];
         case (reg_read_addr)
            2'b00:   reg_read_data <= mtime[31:0];
            2'b01:   reg_read_data <= t_snap;
            2'b10:   reg_read_data <= t_cmp_lo;
            default: reg_read_data <= t_cmp_hi;
         endcase
         if (load_mtimecmp_low)  t_cmp_lo <= mtimecmp_write_data;
         if (load_mtimecmp_high) t_cmp_hi <= mtimecmp_write_data;
      end
   end

   typedef struct {
      logic        re;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
   } req_t;

   typedef struct {
      int          lat;       // ack cycle after accept; 0 means no ack
      logic        err;
      logic        chk_rdata;
      logic [31:0] rdata;
      logic        lo;
      logic        hi;
      logic [31:0] sdata;
   } exp_t;

   typedef struct {
      req_t r;
      exp_t e;
   } vec_t;

   function automatic req_t mkr(input logic re, input logic we, input logic [31:0] a,
                                input logic [31:0] w, input logic [3:0] be);
      req_t r;
      r.re = re; r.we = we; r.addr = a; r.wdata = w; r.be = be;
      return r;
   endfunction

   function automatic exp_t mke(input int lat, input logic err, input logic chk,
                                input logic [31:0] rd, input logic lo, input logic hi,
                                input logic [31:0] sd);
      exp_t e;
      e.lat = lat; e.err = err; e.chk_rdata = chk; e.rdata = rd;
      e.lo = lo; e.hi = hi; e.sdata = sd;
      return e;
   endfunction

   task automatic chk(input string nm, input string what, input logic [63:0] act,
                      input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s.%s: got 0x%0h want 0x%0h", nm, what, act, exp);
      end
   endtask

   // Reference model: register-level view of the timer window.
   logic [31:0] mdl_cmp_lo = 32'h0;
   logic [31:0] mdl_cmp_hi = 32'h0;
   logic [31:0] mdl_snap   = 32'h0;

   task automatic model_step(input req_t r, output exp_t e);
      logic [3:0]  be;
      logic [31:0] old, merged;
      logic [3:0]  ofs;
      e = mke(0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      ofs = r.addr[3:0];
      if (r.addr[31:4] != BASE[31:4] || !(r.re || r.we)) return;
      if (r.addr[1:0] != 2'b00) begin
         e = mke(1, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
      end else if (r.we) begin
         if (ofs < 4'h8) begin
            e = mke(1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
            return;
         end
`ifdef MTIMER_BYTE_ENABLE_EN
         be = r.be;
`else
         be = 4'hF;
`endif
         if (be == 4'h0) begin
            e = mke(1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
            return;
         end
         old = (ofs == 4'hC) ? mdl_cmp_hi : mdl_cmp_lo;
         for (int i = 0; i < 4; i++)
            merged[8*i +: 8] = be[i] ? r.wdata[8*i +: 8] : old[8*i +: 8];
         e = mke((be == 4'hF) ? 1 : 3, 1'b0, 1'b0, 32'h0, ofs == 4'h8, ofs == 4'hC, merged);
         if (ofs == 4'hC) mdl_cmp_hi = merged;
         else             mdl_cmp_lo = merged;
      end else begin
         case (ofs)
            4'h0: begin
               e = mke(3, 1'b0, 1'b1, mtime[31:0], 1'b0, 1'b0, 32'h0);
               mdl_snap = mtime[63:32];
            end
            4'h4:    e = mke(3, 1'b0, 1'b1, mdl_snap, 1'b0, 1'b0, 32'h0);
            4'h8:    e = mke(3, 1'b0, 1'b1, mdl_cmp_lo, 1'b0, 1'b0, 32'h0);
            default: e = mke(3, 1'b0, 1'b1, mdl_cmp_hi, 1'b0, 1'b0, 32'h0);
         endcase
      end
   endtask

   // Issue one request and observe cycles 1..4 after accept.
   task automatic run_txn(input req_t r, input exp_t e, input string nm);
      int ack_n = 0, ack_cyc = 0, stb_n = 0, stb_cyc = 0, dbl_n = 0, rdy_bad = 0;
      logic err_a = 1'b0, lo_a = 1'b0, hi_a = 1'b0;
      logic [31:0] data_a = 32'h0, sdata_a = 32'h0, pre;
      logic exp_rdy;
      @(negedge clk);
      pre            = mem_read_data;
      mem_re         = r.re;
      mem_we         = r.we;
      mem_addr       = r.addr;
      mem_write_data = r.wdata;
      mem_byte_en    = r.be;
      @(posedge clk); #1;
      mem_re = 1'b0;
      mem_we = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         if (mem_ack) begin
            ack_n++;
            if (ack_cyc == 0) begin
               ack_cyc = c; err_a = access_error; data_a = mem_read_data;
            end
         end
         if (load_mtimecmp_low || load_mtimecmp_high) begin
            stb_n++;
            if (load_mtimecmp_low && load_mtimecmp_high) dbl_n++;
            if (stb_cyc == 0) begin
               stb_cyc = c; lo_a = load_mtimecmp_low; hi_a = load_mtimecmp_high;
               sdata_a = mtimecmp_write_data;
            end
         end
         exp_rdy = !(e.lat == 3 && c < 3);
         if (mem_ready !== exp_rdy) rdy_bad++;
         if (c == 3 && e.lat == 3) chk(nm, "sel_after", 64'(reg_read_addr), 64'(2'b10));
         @(posedge clk); #1;
      end
      chk(nm, "ack_count", 64'(ack_n), 64'((e.lat != 0) ? 1 : 0));
      chk(nm, "ack_cycle", 64'(ack_cyc), 64'(e.lat));
      chk(nm, "ready", 64'(rdy_bad), 64'(0));
      chk(nm, "strobe_count", 64'(stb_n), 64'((e.lo || e.hi) ? 1 : 0));
      chk(nm, "dual_strobe", 64'(dbl_n), 64'(0));
      if (e.lat != 0) chk(nm, "access_error", 64'(err_a), 64'(e.err));
      if (e.chk_rdata) chk(nm, "read_data", 64'(data_a), 64'(e.rdata));
      if (e.lat == 0) chk(nm, "read_data_held", 64'(mem_read_data), 64'(pre));
      if (e.lo || e.hi) begin
         chk(nm, "strobe_cycle", 64'(stb_cyc), 64'(e.lat));
         chk(nm, "strobe_lo", 64'(lo_a), 64'(e.lo));
         chk(nm, "strobe_hi", 64'(hi_a), 64'(e.hi));
         chk(nm, "strobe_data", 64'(sdata_a), 64'(e.sdata));
      end
   endtask

   vec_t vecs[12];

   initial begin
      exp_t  me, e1, e2;
      req_t  r, w1, w2;
      int    ack_seen, stb_seen;
      logic  [31:0] a;

      vecs[0]  = '{mkr(0, 1, BASE + 32'h8, 32'h0000_0100, 4'hF), mke(1, 0, 0, 0, 1, 0, 32'h0000_0100)};
      vecs[1]  = '{mkr(1, 0, BASE + 32'h8, 32'h0, 4'hF),         mke(3, 0, 1, 32'h0000_0100, 0, 0, 0)};
      vecs[2]  = '{mkr(0, 1, BASE + 32'h4, 32'h1234_5678, 4'hF), mke(1, 1, 0, 0, 0, 0, 0)};
      vecs[3]  = '{mkr(1, 0, BASE + 32'h9, 32'h0, 4'hF),         mke(1, 1, 1, 32'h0, 0, 0, 0)};
      vecs[4]  = '{mkr(0, 1, BASE + 32'hC, 32'hDEAD_BEEF, 4'hF), mke(1, 0, 0, 0, 0, 1, 32'hDEAD_BEEF)};
      vecs[5]  = '{mkr(1, 0, BASE + 32'hC, 32'h0, 4'hF),         mke(3, 0, 1, 32'hDEAD_BEEF, 0, 0, 0)};
      vecs[6]  = '{mkr(0, 1, 32'h3000_0008, 32'hFFFF_FFFF, 4'hF), mke(0, 0, 0, 0, 0, 0, 0)};
      vecs[7]  = '{mkr(1, 1, BASE + 32'h8, 32'h5555_AAAA, 4'hF), mke(1, 0, 0, 0, 1, 0, 32'h5555_AAAA)};
      vecs[8]  = '{mkr(1, 0, BASE + 32'h8, 32'h0, 4'hF),         mke(3, 0, 1, 32'h5555_AAAA, 0, 0, 0)};
      vecs[9]  = '{mkr(0, 1, BASE + 32'hE, 32'h0BAD_0BAD, 4'hF), mke(1, 1, 1, 32'h0, 0, 0, 0)};
      vecs[10] = '{mkr(1, 0, BASE + 32'h10, 32'h0, 4'hF),        mke(0, 0, 0, 0, 0, 0, 0)};
      vecs[11] = '{mkr(0, 1, BASE + 32'h0, 32'h7777_7777, 4'hF), mke(1, 1, 0, 0, 0, 0, 0)};

      mtime          = 64'h0000_0003_1234_5678;
      reset_n        = 1'b0;
      sync_reset     = 1'b0;
      mem_re         = 1'b0;
      mem_we         = 1'b0;
      mem_addr       = 32'h0;
      mem_write_data = 32'h0;
      mem_byte_en    = 4'hF;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset", "mem_ready", 64'(mem_ready), 64'(1));
      chk("reset", "mem_ack", 64'(mem_ack), 64'(0));
      chk("reset", "access_error", 64'(access_error), 64'(0));
      chk("reset", "strobes", 64'({load_mtimecmp_low, load_mtimecmp_high}), 64'(0));
      chk("reset", "mem_read_data", 64'(mem_read_data), 64'(0));
      chk("reset", "mtimecmp_write_data", 64'(mtimecmp_write_data), 64'(0));
      chk("reset", "reg_read_addr", 64'(reg_read_addr), 64'(2'b10));
      reset_n = 1'b1;

      for (int i = 0; i < 12; i++) begin
         model_step(vecs[i].r, me);
         run_txn(vecs[i].r, vecs[i].e, $sformatf("vec%0d", i));
      end

      // Back-to-back full-word writes accepted in consecutive cycles.
      w1 = mkr(0, 1, BASE + 32'h8, 32'h0A0A_0001, 4'hF);
      w2 = mkr(0, 1, BASE + 32'hC, 32'h0B0B_0002, 4'hF);
      model_step(w1, e1);
      model_step(w2, e2);
      @(negedge clk);
      mem_we = 1'b1; mem_addr = w1.addr; mem_write_data = w1.wdata;
      @(negedge clk);
      chk("b2b", "c1_lo_ack_rdy", 64'({load_mtimecmp_low, load_mtimecmp_high, mem_ack, mem_ready}), 64'(4'b1011));
      chk("b2b", "c1_data", 64'(mtimecmp_write_data), 64'(32'h0A0A_0001));
      mem_addr = w2.addr; mem_write_data = w2.wdata;
      @(negedge clk);
      chk("b2b", "c2_hi_ack", 64'({load_mtimecmp_low, load_mtimecmp_high, mem_ack}), 64'(3'b011));
      chk("b2b", "c2_data", 64'(mtimecmp_write_data), 64'(32'h0B0B_0002));
      mem_we = 1'b0;
      @(negedge clk);
      chk("b2b", "c3_idle", 64'({load_mtimecmp_low, load_mtimecmp_high, mem_ack}), 64'(3'b000));

      // Synchronous reset aborts an in-flight read.
      ack_seen = 0; stb_seen = 0;
      @(negedge clk);
      mem_re = 1'b1; mem_addr = BASE;
      @(posedge clk); #1;
      mem_re = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         if (mem_ack) ack_seen++;
         if (load_mtimecmp_low || load_mtimecmp_high) stb_seen++;
         if (c == 1) sync_reset = 1'b1;
         if (c == 2) begin
            sync_reset = 1'b0;
            chk("sync_abort", "c2_ready", 64'(mem_ready), 64'(1));
            chk("sync_abort", "c2_sel", 64'(reg_read_addr), 64'(2'b10));
         end
         @(posedge clk); #1;
      end
      chk("sync_abort", "acks", 64'(ack_seen), 64'(0));
      chk("sync_abort", "strobes", 64'(stb_seen), 64'(0));

      // Coherent 64-bit mtime across two reads separated by idle cycles.
      mtime = 64'h0000_0001_FFFF_FFFF;
      r = mkr(1, 0, BASE + 32'h0, 32'h0, 4'hF);
      model_step(r, me);
      run_txn(r, mke(3, 0, 1, 32'hFFFF_FFFF, 0, 0, 0), "mtime_lo");
      mtime = 64'h0000_0002_0000_0000;
      repeat (10) @(posedge clk);
      #1;
      r = mkr(1, 0, BASE + 32'h4, 32'h0, 4'hF);
      model_step(r, me);
      run_txn(r, mke(3, 0, 1, 32'h0000_0001, 0, 0, 0), "mtime_hi");

`ifdef MTIMER_BYTE_ENABLE_EN
      r = mkr(0, 1, BASE + 32'h8, 32'h1122_3344, 4'hF);
      model_step(r, me);
      run_txn(r, mke(1, 0, 0, 0, 1, 0, 32'h1122_3344), "rmw_pre");
      r = mkr(0, 1, BASE + 32'h8, 32'hAABB_CCDD, 4'b0010);
      model_step(r, me);
      run_txn(r, mke(3, 0, 0, 0, 1, 0, 32'h1122_CC44), "rmw");
      r = mkr(1, 0, BASE + 32'h8, 32'h0, 4'hF);
      model_step(r, me);
      run_txn(r, mke(3, 0, 1, 32'h1122_CC44, 0, 0, 0), "rmw_read");
      r = mkr(0, 1, BASE + 32'hC, 32'h9999_9999, 4'h0);
      model_step(r, me);
      run_txn(r, mke(1, 0, 0, 0, 0, 0, 0), "be_zero");
`endif

      // Randomized traffic against the reference model.
      for (int i = 0; i < 80; i++) begin
         a = BASE + 32'($urandom_range(0, 3) * 4);
         if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
         if ($urandom_range(0, 9) == 0) a = a ^ 32'h0100_0000;
         case ($urandom_range(0, 7))
            0, 1, 2: r = mkr(1, 0, a, $urandom, 4'($urandom));
            3, 4, 5: r = mkr(0, 1, a, $urandom, 4'($urandom));
            6:       r = mkr(1, 1, a, $urandom, 4'($urandom));
            default: r = mkr(0, 0, a, $urandom, 4'($urandom));
         endcase
         if ($urandom_range(0, 2) != 0) r.be = 4'hF;
         if ($urandom_range(0, 3) == 0) mtime = mtime + 64'($urandom_range(1, 100000));
         model_step(r, me);
         run_txn(r, me, $sformatf("rnd%0d", i));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
